hdlc_tx_framer: RTL and testbench

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

---
 rtl/hdlc_tx_framer.sv | 183 ++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: start/end flags, zero-bit stuffing and abort sequence on a registered serial line.
// Tx_DataReady is registered and refers to the bit currently on Tx.
module hdlc_tx_framer #(
  parameter int unsigned MAX_FRAME_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_Last,
  output logic       Tx_DataReady,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam int unsigned BitCntW  = 3;
  localparam int unsigned ByteCntW = 8;
  localparam int unsigned ByteW    = 8;
  localparam logic [ByteW-1:0] FlagPat  = 8'h7E;
  localparam logic [ByteW-1:0] AbortPat = 8'hFE;

  typedef enum logic [2:0] {IDLE, START_FLAG, DATA, END_FLAG, ABORT} stateT;

  stateT               state, stateNext;
  logic [BitCntW-1:0]  bitCnt, bitCntNext, bitInc;
  logic [BitCntW-1:0]  onesCnt, onesNext;
  logic [ByteCntW-1:0] byteCnt, byteCntNext;
  logic [ByteW-1:0]    shiftReg, shiftNext, nextByte;
  logic                lastByte, lastNext;
  logic                newByte, newByteNext;
  logic                stuffing, stuffNext;
  logic                dataBitNext;
  logic                frameActive, xfer, abortTrig;
  logic                txNext, validNext, readyNext, abortedNext, doneNext;

  // State, datapath and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      bitCnt          <= '0;
      onesCnt         <= '0;
      byteCnt         <= '0;
      shiftReg        <= '0;
      lastByte        <= 1'b0;
      newByte         <= 1'b0;
      stuffing        <= 1'b0;
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_DataReady    <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Done         <= 1'b0;
    end else begin
      state           <= stateNext;
      bitCnt          <= bitCntNext;
      onesCnt         <= onesNext;
      byteCnt         <= byteCntNext;
      shiftReg        <= shiftNext;
      lastByte        <= lastNext;
      newByte         <= newByteNext;
      stuffing        <= stuffNext;
      Tx              <= txNext;
      Tx_ValidFrame   <= validNext;
      Tx_DataReady    <= readyNext;
      Tx_AbortedTrans <= abortedNext;
      Tx_Done         <= doneNext;
    end
  end

  // Next state and datapath; state describes the bit currently on Tx
  always_comb begin
    stateNext   = state;
    bitCntNext  = bitCnt;
    onesNext    = onesCnt;
    byteCntNext = byteCnt;
    shiftNext   = shiftReg;
    lastNext    = lastByte;
    newByteNext = newByte;
    stuffNext   = 1'b0;
    dataBitNext = 1'b1;
    bitInc      = bitCnt + BitCntW'(1);

    frameActive = (state == START_FLAG) || (state == DATA) || (state == END_FLAG);
    abortTrig   = frameActive && (Tx_AbortFrame || (Tx_DataReady && !Tx_DataValid) ||
                  (Tx_DataReady && Tx_DataValid && (32'(byteCnt) >= MAX_FRAME_BYTES)));
    xfer        = Tx_DataReady && Tx_DataValid && !abortTrig;
    nextByte    = xfer ? Tx_Data : shiftReg;

    if (xfer) begin
      shiftNext   = Tx_Data;
      lastNext    = Tx_Last;
      byteCntNext = (byteCnt == '1) ? byteCnt : byteCnt + ByteCntW'(1);
    end

    case (state)
      IDLE: begin
        if (Tx_DataValid) begin
          stateNext   = START_FLAG;
          bitCntNext  = '0;
          byteCntNext = '0;
        end
      end
      START_FLAG: begin
        if (bitCnt == BitCntW'(7)) begin
          stateNext   = DATA;
          bitCntNext  = '0;
          dataBitNext = Tx_Data[0];
          onesNext    = BitCntW'(Tx_Data[0]);
          newByteNext = 1'b0;
        end else begin
          bitCntNext = bitInc;
        end
      end
      DATA: begin
        if (!stuffing && (onesCnt == BitCntW'(5))) begin
          // A byte accepted here is held until the stuff bit has gone out
          stuffNext   = 1'b1;
          onesNext    = '0;
          newByteNext = xfer;
        end else if ((bitCnt == BitCntW'(7)) && lastByte && !newByte) begin
          stateNext  = END_FLAG;
          bitCntNext = '0;
          onesNext   = '0;
        end else begin
          bitCntNext  = bitInc;
          dataBitNext = nextByte[bitInc];
          onesNext    = dataBitNext ? onesCnt + BitCntW'(1) : '0;
          newByteNext = 1'b0;
        end
      end
      END_FLAG, ABORT: begin
        if (bitCnt == BitCntW'(7)) begin
          stateNext  = IDLE;
          bitCntNext = '0;
        end else begin
          bitCntNext = bitInc;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (abortTrig) begin
      stateNext   = ABORT;
      bitCntNext  = '0;
      onesNext    = '0;
      stuffNext   = 1'b0;
      newByteNext = 1'b0;
    end
  end

  // Registered output values for the bit about to be placed on Tx
  always_comb begin
    txNext      = 1'b1;
    validNext   = 1'b0;
    readyNext   = 1'b0;
    abortedNext = 1'b0;
    doneNext    = (state == END_FLAG) && (stateNext == IDLE);
    case (stateNext)
      START_FLAG: begin
        txNext    = FlagPat[bitCntNext];
        validNext = 1'b1;
        readyNext = (bitCntNext == BitCntW'(7));
      end
      DATA: begin
        txNext    = stuffNext ? 1'b0 : dataBitNext;
        validNext = 1'b1;
        readyNext = (bitCntNext == BitCntW'(7)) && !stuffNext && !lastNext;
      end
      END_FLAG: begin
        txNext    = FlagPat[bitCntNext];
        validNext = 1'b1;
      end
      ABORT: begin
        txNext      = AbortPat[bitCntNext];
        abortedNext = (state != ABORT);
      end
      default: txNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: frame-level bit-list model feeds a per-cycle scoreboard checked by a monitor.
module tb_hdlc_tx_framer;

  localparam int MaxBytes = 128;

  logic       Clk;
  logic       Rst;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_Last;
  logic       Tx_DataReady;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  hdlc_tx_framer #(.MAX_FRAME_BYTES(MaxBytes)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Tx_DataValid(Tx_DataValid),
    .Tx_Last(Tx_Last), .Tx_DataReady(Tx_DataReady), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_AbortedTrans(Tx_AbortedTrans),
    .Tx_Done(Tx_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic tx;
    logic vf;
    logic rdy;
    logic ab;
    logic dn;
  } expT;

  expT        expQ[$];
  expT        frameExp[$];
  int         reqCyc[$];
  logic [7:0] frameData[$];
  int         lastVfCyc;
  logic [7:0] flagPat = 8'h7E;
  int         nTests = 0;
  int         nFail = 0;
  bit         monOn = 1'b0;

  function automatic expT mk(logic tx, logic vf, logic rdy, logic ab, logic dn);
    expT e;
    e.tx = tx; e.vf = vf; e.rdy = rdy; e.ab = ab; e.dn = dn;
    return e;
  endfunction

  // Expected line behaviour for an unperturbed frame, one entry per cycle from the start request
  task automatic build_normal();
    int ones;
    int n;
    logic b;
    n = frameData.size();
    frameExp.delete();
    reqCyc.delete();
    frameExp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) frameExp.push_back(mk(flagPat[k], 1'b1, k == 7, 1'b0, 1'b0));
    reqCyc.push_back(8);
    ones = 0;
    for (int by = 0; by < n; by++) begin
      for (int i = 0; i < 8; i++) begin
        b = frameData[by][i];
        frameExp.push_back(mk(b, 1'b1, (i == 7) && (by != n - 1), 1'b0, 1'b0));
        if ((i == 7) && (by != n - 1)) reqCyc.push_back(frameExp.size() - 1);
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin
          frameExp.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
          ones = 0;
        end
      end
    end
    for (int k = 0; k < 8; k++) frameExp.push_back(mk(flagPat[k], 1'b1, 1'b0, 1'b0, 1'b0));
    lastVfCyc = frameExp.size() - 1;
    frameExp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Truncate at the trigger cycle and append either the abort pattern or post-reset idle
  task automatic apply_cut(input int cut, input bit isRst);
    while (frameExp.size() > cut + 1) void'(frameExp.pop_back());
    if (isRst) begin
      repeat (2) frameExp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      for (int k = 0; k < 8; k++) frameExp.push_back(mk(k != 0, 1'b0, 1'b0, k == 0, 1'b0));
      frameExp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // Called just after a rising edge with frameData filled and build_normal() done
  task automatic run_frame(input int abortAt, input int dropIdx, input int rstAt);
    int  cut;
    bit  isRst;
    int  n;
    int  idx;
    int  len;
    bit  xferSeen;
    n = frameData.size();
    cut = -1;
    isRst = 1'b0;
    if (abortAt >= 1) cut = abortAt;
    if (dropIdx >= 0 && dropIdx < reqCyc.size() && (cut < 0 || reqCyc[dropIdx] < cut))
      cut = reqCyc[dropIdx];
    if (n > MaxBytes && (cut < 0 || reqCyc[MaxBytes] < cut)) cut = reqCyc[MaxBytes];
    if (rstAt >= 1 && (cut < 0 || rstAt < cut)) begin
      cut = rstAt;
      isRst = 1'b1;
    end
    if (cut >= 0) apply_cut(cut, isRst);
    foreach (frameExp[i]) expQ.push_back(frameExp[i]);
    len = frameExp.size();
    idx = 0;
    for (int cyc = 0; cyc < len; cyc++) begin
      Tx_AbortFrame = (cyc == abortAt);
      Rst = (cyc == rstAt);
      if (cyc == 0 || ((cut < 0 || cyc <= cut) && idx < n && idx != dropIdx)) begin
        Tx_DataValid = 1'b1;
        Tx_Data = frameData[idx];
        Tx_Last = (idx == n - 1);
      end else begin
        Tx_DataValid = 1'b0;
        Tx_Data = 8'h00;
        Tx_Last = 1'b0;
      end
      @(negedge Clk);
      xferSeen = Tx_DataReady && Tx_DataValid && !Tx_AbortFrame;
      @(posedge Clk);
      #1;
      if (xferSeen) idx++;
    end
    Tx_AbortFrame = 1'b0;
    Rst = 1'b0;
    Tx_DataValid = 1'b0;
    Tx_Data = 8'h00;
    Tx_Last = 1'b0;
  endtask

  task automatic idle_gap(input int cycles);
    repeat (cycles) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic set_data2(input logic [7:0] a, input logic [7:0] b, input int cnt);
    frameData.delete();
    frameData.push_back(a);
    if (cnt > 1) frameData.push_back(b);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] v;
    case ($urandom_range(0, 5))
      0: v = 8'hFF;
      1: v = 8'h7E;
      2: v = 8'hF8;
      3: v = 8'h1F;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: compares every cycle against the scoreboard head, idle line when empty
  initial begin
    expT want;
    expT got;
    wait (monOn);
    forever begin
      @(negedge Clk);
      want = (expQ.size() > 0) ? expQ.pop_front() : mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      got = {Tx, Tx_ValidFrame, Tx_DataReady, Tx_AbortedTrans, Tx_Done};
      nTests++;
      if (got !== want) begin
        nFail++;
        $display("FAIL line_check t=%0t tx/vf/rdy/ab/dn got=%b required=%b", $time, got, want);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int n;
    Rst = 1'b1;
    Tx_Data = 8'h00;
    Tx_DataValid = 1'b0;
    Tx_Last = 1'b0;
    Tx_AbortFrame = 1'b0;
    @(posedge Clk);
    monOn = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    idle_gap(2);

    set_data2(8'h00, 8'h00, 1); build_normal(); run_frame(-1, -1, -1);
    set_data2(8'hFF, 8'h00, 1); build_normal(); run_frame(-1, -1, -1);
    set_data2(8'hF8, 8'h0F, 2); build_normal(); run_frame(-1, -1, -1);
    set_data2(8'h55, 8'hAA, 2); frameData.push_back(8'h33); build_normal(); run_frame(20, -1, -1);
    set_data2(8'h12, 8'h34, 2); frameData.push_back(8'h56); build_normal(); run_frame(-1, 1, -1);
    set_data2(8'h12, 8'h34, 2); build_normal(); run_frame(-1, 0, -1);
    set_data2(8'hFF, 8'h00, 2); build_normal(); run_frame(14, -1, -1);
    set_data2(8'hA5, 8'h5A, 2); build_normal(); run_frame(8, -1, -1);
    set_data2(8'hA5, 8'h5A, 2); build_normal(); run_frame(0, -1, -1);
    set_data2(8'h3C, 8'hC3, 2); build_normal(); run_frame(lastVfCyc, -1, -1);
    set_data2(8'hF0, 8'h0F, 2); build_normal(); run_frame(-1, -1, 12);
    set_data2(8'hFE, 8'h7F, 2); build_normal(); run_frame(-1, -1, -1);

    frameData.delete();
    for (int i = 0; i < MaxBytes + 1; i++) frameData.push_back(8'($urandom));
    build_normal();
    run_frame(-1, -1, -1);
    idle_gap(1);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 6);
      frameData.delete();
      for (int i = 0; i < n; i++) frameData.push_back(rand_byte());
      build_normal();
      kind = $urandom_range(0, 9);
      if (kind < 6) run_frame(-1, -1, -1);
      else if (kind < 8) run_frame($urandom_range(1, lastVfCyc), -1, -1);
      else if (kind < 9) run_frame(-1, $urandom_range(0, n - 1), -1);
      else run_frame(-1, -1, $urandom_range(1, lastVfCyc));
      idle_gap($urandom_range(0, 3));
    end

    idle_gap(4);
    if (expQ.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL drain_check: %0d expected entries left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
